// File: rtl/fetch_redirect_ctrl_pkg.sv
// +-----------------------------------------------------------------------------+
// | fetch_redirect_ctrl_pkg : redirect source / state encodings and defaults     |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

package fetch_redirect_ctrl_pkg;

  localparam int MAX_INFLIGHT_DEF = 2;

  // Lower encoding means higher priority (and an older instruction).
  typedef enum logic [1:0] {
    REDIR_SRC_TRAP = 2'd0,
    REDIR_SRC_JALR = 2'd1,
    REDIR_SRC_BR   = 2'd2,
    REDIR_SRC_JAL  = 2'd3
  } redir_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } redir_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_inflight_ctr.sv
// +-----------------------------------------------------------------------------+
// | fetch_inflight_ctr : outstanding I-fetch counter and stale-response dropping |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_inflight_ctr #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CW           = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_fire,
  input  logic          if_rsp_valid,
  input  logic          redir_valid,
  output logic [CW-1:0] outstanding,
  output logic          if_req_allow,
  output logic          if_rsp_drop,
  output logic          drain_next
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Illegal fire-when-full / response-when-empty saturate instead of wrapping.
  always_comb begin
    outstanding_d = outstanding_q;
    if (if_req_fire && !if_rsp_valid) begin
      if (outstanding_q != MAX_CNT) outstanding_d = outstanding_q + CW'(1);
    end else if (!if_req_fire && if_rsp_valid) begin
      if (outstanding_q != '0) outstanding_d = outstanding_q - CW'(1);
    end
  end

  // A request fired in the redirect cycle used the old PC, so it is stale too.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redir_valid) begin
      drop_cnt_d = outstanding_d;
    end else if (if_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign outstanding  = outstanding_q;
  assign if_req_allow = (outstanding_q < MAX_CNT);
  assign if_rsp_drop  = if_rsp_valid && (redir_valid || (drop_cnt_q != '0));
  assign drain_next   = (drop_cnt_d != '0);

  a_no_fire_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_req_fire && (outstanding_q == MAX_CNT)));
  a_no_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_rsp_valid && (outstanding_q == '0)));

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
// +-----------------------------------------------------------------------------+
// | fetch_redirect_ctrl : prioritised fetch-PC redirect, hold and flush control  |
// | Optional perf counters under macro REDIR_PERF_EN.  Revision: 1.0             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trap_req,
  input  logic [63:0]   trap_addr,
  input  logic          jalr_req,
  input  logic [63:0]   jalr_addr,
  input  logic          br_miss_req,
  input  logic [63:0]   br_addr,
  input  logic          jal_req,
  input  logic [63:0]   jal_addr,
  input  logic          stall,
  input  logic          if_req_fire,
  input  logic          if_rsp_valid,
  output logic          redir_valid,
  output logic [1:0]    redir_src,
  output logic [63:0]   redir_addr,
  output logic          flush_if,
  output logic          flush_id,
  output logic          if_rsp_drop,
  output logic          if_req_allow,
  output logic          held,
  output logic [CW-1:0] outstanding,
  output logic [31:0]   perf_redir_cnt,
  output logic [31:0]   perf_drop_cnt
);

  redir_state_e state_q, state_d;
  redir_src_e   held_src_q, held_src_d;
  logic [63:0]  held_addr_q, held_addr_d;

  redir_src_e   hi_src, lo_src, cand_src, sel_src;
  logic [63:0]  hi_addr, lo_addr, cand_addr;
  logic         hi_req, lo_req, take_new, drain_next;

  assign hi_req  = trap_req | jalr_req;
  assign hi_src  = trap_req ? REDIR_SRC_TRAP : REDIR_SRC_JALR;
  assign hi_addr = trap_req ? trap_addr : jalr_addr;
  assign lo_req  = br_miss_req | jal_req;
  assign lo_src  = br_miss_req ? REDIR_SRC_BR : REDIR_SRC_JAL;
  assign lo_addr = br_miss_req ? br_addr : jal_addr;

  // Equal/lower priority requests in HOLD come from a younger path and are ignored.
  assign take_new  = lo_req && ((state_q != ST_HOLD) || (lo_src < held_src_q));
  assign cand_src  = take_new ? lo_src : held_src_q;
  assign cand_addr = take_new ? lo_addr : held_addr_q;

  always_comb begin
    redir_valid = 1'b0;
    sel_src     = REDIR_SRC_TRAP;
    redir_addr  = '0;
    held_src_d  = held_src_q;
    held_addr_d = held_addr_q;
    if (hi_req) begin
      redir_valid = 1'b1;
      sel_src     = hi_src;
      redir_addr  = hi_addr;
    end else if ((state_q == ST_HOLD) || lo_req) begin
      if (stall) begin
        held_src_d  = cand_src;
        held_addr_d = cand_addr;
      end else begin
        redir_valid = 1'b1;
        sel_src     = cand_src;
        redir_addr  = cand_addr;
      end
    end
    if (redir_valid) begin
      held_src_d  = REDIR_SRC_TRAP;
      held_addr_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redir_valid) begin
      state_d = drain_next ? ST_DRAIN : ST_IDLE;
    end else if (lo_req && stall) begin
      state_d = ST_HOLD;
    end else if ((state_q == ST_DRAIN) && !drain_next) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      held_src_q  <= REDIR_SRC_TRAP;
      held_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      held_src_q  <= held_src_d;
      held_addr_q <= held_addr_d;
    end
  end

  assign redir_src = sel_src;
  assign flush_if  = redir_valid;
  assign flush_id  = redir_valid;
  assign held      = (state_q == ST_HOLD);

  fetch_inflight_ctr #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CW           (CW)
  ) u_inflight (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_fire  (if_req_fire),
    .if_rsp_valid (if_rsp_valid),
    .redir_valid  (redir_valid),
    .outstanding  (outstanding),
    .if_req_allow (if_req_allow),
    .if_rsp_drop  (if_rsp_drop),
    .drain_next   (drain_next)
  );

`ifdef REDIR_PERF_EN
  logic [31:0] perf_redir_cnt_q, perf_redir_cnt_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_redir_cnt_d = perf_redir_cnt_q;
    perf_drop_cnt_d  = perf_drop_cnt_q;
    if (redir_valid && (perf_redir_cnt_q != 32'hFFFF_FFFF))
      perf_redir_cnt_d = perf_redir_cnt_q + 32'd1;
    if (if_rsp_drop && (perf_drop_cnt_q != 32'hFFFF_FFFF))
      perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redir_cnt_q <= '0;
      perf_drop_cnt_q  <= '0;
    end else begin
      perf_redir_cnt_q <= perf_redir_cnt_d;
      perf_drop_cnt_q  <= perf_drop_cnt_d;
    end
  end

  assign perf_redir_cnt = perf_redir_cnt_q;
  assign perf_drop_cnt  = perf_drop_cnt_q;
`else
  assign perf_redir_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_fetch_redirect_ctrl : scoreboard bench for fetch_redirect_ctrl            |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_redirect_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trap_req, jalr_req, br_miss_req, jal_req;
  logic [63:0]   trap_addr, jalr_addr, br_addr, jal_addr;
  logic          stall, if_req_fire, if_rsp_valid;
  logic          redir_valid, flush_if, flush_id, if_rsp_drop, if_req_allow, held;
  logic [1:0]    redir_src;
  logic [63:0]   redir_addr;
  logic [CW-1:0] outstanding;
  logic [31:0]   perf_redir_cnt, perf_drop_cnt;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.MAX_INFLIGHT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_req       (trap_req),
    .trap_addr      (trap_addr),
    .jalr_req       (jalr_req),
    .jalr_addr      (jalr_addr),
    .br_miss_req    (br_miss_req),
    .br_addr        (br_addr),
    .jal_req        (jal_req),
    .jal_addr       (jal_addr),
    .stall          (stall),
    .if_req_fire    (if_req_fire),
    .if_rsp_valid   (if_rsp_valid),
    .redir_valid    (redir_valid),
    .redir_src      (redir_src),
    .redir_addr     (redir_addr),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .if_rsp_drop    (if_rsp_drop),
    .if_req_allow   (if_req_allow),
    .held           (held),
    .outstanding    (outstanding),
    .perf_redir_cnt (perf_redir_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] addr;
  } redir_t;

  redir_t redir_q[$];
  bit     drop_q[$];
  int     checks = 0;
  int     errors = 0;
  int     exp_redir_n = 0;
  int     exp_drop_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trap_req = 0; jalr_req = 0; br_miss_req = 0; jal_req = 0;
    trap_addr = '0; jalr_addr = '0; br_addr = '0; jal_addr = '0;
    stall = 0; if_req_fire = 0; if_rsp_valid = 0;
  endtask

  task automatic exp_redir(input logic [1:0] src, input logic [63:0] addr);
    redir_q.push_back('{src: src, addr: addr});
    exp_redir_n++;
  endtask

  task automatic exp_rsp(input bit d);
    drop_q.push_back(d);
    if (d) exp_drop_n++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_redir_valid"}, redir_valid, 0);
    chk({tag, "_redir_src"}, redir_src, 0);
    chk({tag, "_redir_addr"}, redir_addr, 0);
    chk({tag, "_flush_if"}, flush_if, 0);
    chk({tag, "_flush_id"}, flush_id, 0);
    chk({tag, "_rsp_drop"}, if_rsp_drop, 0);
    chk({tag, "_req_allow"}, if_req_allow, 1);
    chk({tag, "_held"}, held, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_perf_redir"}, perf_redir_cnt, 0);
    chk({tag, "_perf_drop"}, perf_drop_cnt, 0);
  endtask

  task automatic chk_perf(input string tag);
`ifdef REDIR_PERF_EN
    chk({tag, "_perf_redir"}, perf_redir_cnt, exp_redir_n);
    chk({tag, "_perf_drop"}, perf_drop_cnt, exp_drop_n);
`else
    chk({tag, "_perf_redir"}, perf_redir_cnt, 0);
    chk({tag, "_perf_drop"}, perf_drop_cnt, 0);
`endif
  endtask

  // Monitor: consumes expectations whenever the DUT presents a redirect or response.
  redir_t m_exp;
  bit     m_drop;
  always @(negedge clk) begin
    if (redir_valid) begin
      if (redir_q.size() == 0) begin
        chk("redir_unexpected", redir_valid, 0);
      end else begin
        m_exp = redir_q.pop_front();
        chk("redir_src", redir_src, m_exp.src);
        chk("redir_addr", redir_addr, m_exp.addr);
        chk("flush_if", flush_if, 1);
        chk("flush_id", flush_id, 1);
      end
    end
    if (if_rsp_valid) begin
      if (drop_q.size() == 0) begin
        chk("rsp_unexpected", if_rsp_valid, 0);
      end else begin
        m_drop = drop_q.pop_front();
        chk("rsp_drop", if_rsp_drop, m_drop);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    tick(); rst_n = 1;

    // Unstalled branch mispredict redirects in the same cycle
    tick(); clr(); br_miss_req = 1; br_addr = 64'h8000_0100; exp_redir(2, 64'h8000_0100);
    #2 chk("br_same_cycle", redir_valid, 1);
    tick(); clr(); #2 chk("br_not_held", held, 0); chk("br_outstanding", outstanding, 0);

    // Priority: trap beats everything; jalr beats br/jal even when stalled
    tick(); clr(); trap_req = 1; trap_addr = 64'hA000; jalr_req = 1; jalr_addr = 64'hB000;
    br_miss_req = 1; br_addr = 64'hC000; jal_req = 1; jal_addr = 64'hD000; exp_redir(0, 64'hA000);
    tick(); clr(); stall = 1; jalr_req = 1; jalr_addr = 64'hB000; br_miss_req = 1; br_addr = 64'hC000;
    jal_req = 1; jal_addr = 64'hD000; exp_redir(1, 64'hB000);

    // HOLD: jal held, replaced by higher-priority br, lower-priority jal ignored
    tick(); clr(); stall = 1; jal_req = 1; jal_addr = 64'h200;
    tick(); clr(); stall = 1; #2 chk("hold_held", held, 1); br_miss_req = 1; br_addr = 64'h300;
    tick(); clr(); stall = 1; jal_req = 1; jal_addr = 64'h350;
    tick(); clr(); exp_redir(2, 64'h300);
    tick(); clr(); #2 chk("hold_released", held, 0);

    // HOLD with equal-priority br ignored
    tick(); clr(); stall = 1; br_miss_req = 1; br_addr = 64'h500;
    tick(); clr(); stall = 1; br_miss_req = 1; br_addr = 64'h580;
    tick(); clr(); exp_redir(2, 64'h500);

    // Trap wins immediately while in HOLD
    tick(); clr(); stall = 1; jal_req = 1; jal_addr = 64'h400;
    tick(); clr(); stall = 1; trap_req = 1; trap_addr = 64'h1000; exp_redir(0, 64'h1000);
    tick(); clr(); stall = 1; #2 chk("trap_clears_held", held, 0);
    tick(); clr();

    // Drain: two in flight, jalr with simultaneous response
    tick(); clr(); if_req_fire = 1;
    tick(); clr(); if_req_fire = 1;
    tick(); clr(); #2 chk("full_outstanding", outstanding, 2); chk("full_allow", if_req_allow, 0);
    jalr_req = 1; jalr_addr = 64'h700; if_rsp_valid = 1; exp_redir(1, 64'h700); exp_rsp(1);
    tick(); clr(); #2 chk("drain_outstanding", outstanding, 1); if_rsp_valid = 1; exp_rsp(1);
    tick(); clr(); #2 chk("drained_outstanding", outstanding, 0); chk_perf("drain");

    // Counter: simultaneous fire+rsp, allow recovers after a response
    tick(); clr(); if_req_fire = 1;
    tick(); clr(); if_req_fire = 1; if_rsp_valid = 1; exp_rsp(0);
    tick(); clr(); #2 chk("fire_rsp_same", outstanding, 1); if_req_fire = 1;
    tick(); clr(); #2 chk("allow_full", if_req_allow, 0); if_rsp_valid = 1; exp_rsp(0);
    tick(); clr(); #2 chk("allow_back", if_req_allow, 1); chk("one_left", outstanding, 1);
    if_rsp_valid = 1; exp_rsp(0);
    tick(); clr(); #2 chk("empty_again", outstanding, 0);

    // Request fired in redirect cycle is stale; then reset during DRAIN
    tick(); clr(); if_req_fire = 1;
    tick(); clr(); if_req_fire = 1; br_miss_req = 1; br_addr = 64'h900; exp_redir(2, 64'h900);
    tick(); clr(); #2 chk("stale_outstanding", outstanding, 2); if_rsp_valid = 1; exp_rsp(1);
    tick(); clr(); rst_n = 0; #1 chk_reset("rst_drain");
    exp_redir_n = 0; exp_drop_n = 0;
    tick(); rst_n = 1;
    tick(); clr(); if_req_fire = 1;
    tick(); clr(); if_rsp_valid = 1; exp_rsp(0);
    tick(); clr(); #2 chk("post_rst_outstanding", outstanding, 0); chk_perf("post_rst");

    repeat (2) tick();
    chk("redir_queue_empty", redir_q.size(), 0);
    chk("drop_queue_empty", drop_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences all fetch-PC redirects. Arbitrates trap, jalr, branch-mispredict and jal redirect requests into one prioritised redirect toward the PC register.
- Holds a stall-blocked redirect until it can be applied, and generates front-end flushes.
- Tracks outstanding I-fetch requests so that stale responses from the old path are dropped after a redirect.
- Sits between execute/trap logic and the PC/fetch stage.

Parameters:
- MAX_INFLIGHT, 2, maximum outstanding I-fetch requests; counter width CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- trap_req  in  1  trap/exception redirect request
- trap_addr  in  64  trap target
- jalr_req  in  1  jalr redirect request
- jalr_addr  in  64  jalr target
- br_miss_req  in  1  branch mispredict redirect request
- br_addr  in  64  corrected branch target
- jal_req  in  1  jal redirect request
- jal_addr  in  64  jal target
- stall  in  1  front-end stall
- if_req_fire  in  1  fetch request accepted by I-cache this cycle
- if_rsp_valid  in  1  fetch response returned this cycle
- redir_valid  out  1  apply redirect this cycle
- redir_src  out  2  source of the applied redirect
- redir_addr  out  64  redirect target
- flush_if  out  1  kill the IF stage
- flush_id  out  1  kill the ID stage
- if_rsp_drop  out  1  discard the current fetch response
- if_req_allow  out  1  a new fetch request may issue
- held  out  1  a redirect is pending in HOLD
- outstanding  out  CW  outstanding fetch count
- perf_redir_cnt  out  32  see Optional Feature
- perf_drop_cnt  out  32  see Optional Feature

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, held register cleared, outstanding=0, drop_cnt=0, perf counters 0. All outputs are 0 except if_req_allow=1. Reset in any state aborts that state, including a pending HOLD redirect and an active drain; the pending target is lost.
- Priority: trap > jalr > br_miss > jal. Encoding: TRAP=0, JALR=1, BR=2, JAL=3.
- Trap and jalr redirect regardless of stall: redir_valid asserts combinationally in the same cycle, with the source's addr/src. They are never held.
- br_miss and jal with stall=0, in IDLE or DRAIN: redir_valid in the same cycle.
- br_miss and jal with stall=1: latch {src, addr}; go to HOLD; held=1; redir_valid=0.
- HOLD:
  - Stall deasserts: redir_valid=1 from the latched register in that cycle, then go to DRAIN or IDLE.
  - A new trap/jalr arrives: it wins immediately and the held entry is cleared.
  - A new br_miss or jal arrives while stalled: it replaces the held entry only if strictly higher priority. Equal or lower priority is ignored, because it belongs to a younger path.
- flush_if=flush_id=redir_valid. One pulse per applied redirect.
- outstanding_next = outstanding + if_req_fire - if_rsp_valid. Simultaneous fire and response leave it unchanged.
- if_req_allow = (outstanding < MAX_INFLIGHT).
- A fire while outstanding==MAX_INFLIGHT is illegal: assertion fires, counter saturates.
- A response while outstanding==0 is illegal: assertion fires, counter holds 0.
- On redirect: drop_cnt_next = outstanding + if_req_fire - if_rsp_valid. A request fired in the redirect cycle used the old PC and is counted as stale.
- if_rsp_drop = if_rsp_valid && (redir_valid || drop_cnt != 0).
- A dropped response outside the redirect cycle decrements drop_cnt.
- State after a redirect: drop_cnt_next > 0 gives DRAIN, otherwise IDLE.
- DRAIN exits to IDLE when drop_cnt reaches 0. A redirect during DRAIN reloads drop_cnt from the formula above; this is not additive.

Optional Feature:
- Macro: REDIR_PERF_EN.
- Defined: perf_redir_cnt increments per redir_valid; perf_drop_cnt increments per if_rsp_drop. Both are 32-bit, saturate at 0xFFFF_FFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared config header/package: REDIR_SRC_TRAP/JALR/BR/JAL encodings, state encodings IDLE/HOLD/DRAIN, and the MAX_INFLIGHT default.
- One sub-module: fetch_inflight_ctr, holding the outstanding counter, drop_cnt, if_req_allow and if_rsp_drop logic.

Test Plan:
- Reset, then br_miss_req=1, br_addr=0x8000_0100, stall=0 -> same cycle: redir_valid=1, src=2, addr=0x8000_0100, flush_if=flush_id=1; state IDLE.
- stall=1, jal_req (addr 0x200) -> held=1, no redir. Then br_miss (0x300) while stalled -> held entry becomes src=2/0x300. Then stall=0 -> redir_valid, addr=0x300.
- In HOLD with stall=1, trap_req (addr 0x1000) -> redir_valid same cycle, src=0, addr=0x1000; held=0.
- Two fires (outstanding=2), then jalr redirect with a simultaneous response -> that response is dropped; drop_cnt=1; the next response is dropped; state returns to IDLE; perf_drop_cnt=2 (REDIR_PERF_EN).
- outstanding=2 -> if_req_allow=0. A response arrives -> if_req_allow=1 the next cycle.
- rst_n asserted during DRAIN with drop_cnt=1 -> all outputs are at reset values immediately; the next response is not dropped.
